mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch waits.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req / if_addr  in  1 / ADDR_W  fetch read request and address; held until if_ready.
REQ-007 if_rdata / if_ready  out  DATA_W / 1  fetch read data; one-cycle completion pulse.
REQ-008 dm_re / dm_we  in  1 / 1  data-stage MemRead / MemWrite; held until dm_ready.
REQ-009 dm_addr / dm_wdata  in  ADDR_W / DATA_W  data-stage address and store data.
REQ-010 dm_rdata / dm_ready  out  DATA_W / 1  load data; one-cycle completion pulse.
REQ-011 mem_en / mem_we  out  1 / 1  single-port memory strobe and write select.
REQ-012 mem_addr / mem_wdata  out  ADDR_W / DATA_W  latched address and write data.
REQ-013 mem_rdata / mem_valid  in  DATA_W / 1  memory read data; completion, one or more cycles after mem_en.

Function
REQ-014 FSM states: IDLE, IF_WAIT, DM_WAIT, DONE; all outputs registered.
REQ-015 IDLE, no request: stay IDLE; mem_en=0.
REQ-016 IDLE, request sampled at edge: latch addr/wdata/we into mem_* regs; enter IF_WAIT or DM_WAIT; mem_en=1 for exactly that first wait cycle.
REQ-017 Priority: data (dm_re|dm_we) over fetch, unless starve_cnt==STARVE_MAX and if_req=1, then fetch is granted.
REQ-018 starve_cnt increments on each data grant while if_req=1; clears on fetch grant or on any grant with if_req=0; saturates at STARVE_MAX.
REQ-019 dm_re and dm_we both high: treated as write (mem_we=1); dm_rdata unchanged.
REQ-020 *_WAIT: mem_en=0; hold mem_addr/mem_wdata/mem_we stable; ignore new requests until mem_valid.
REQ-021 mem_valid in *_WAIT: capture mem_rdata into if_rdata or dm_rdata (reads only); enter DONE.
REQ-022 DONE: matching ready=1 for exactly one cycle; do not sample requests; next state IDLE.
REQ-023 Minimum transaction cadence is 3 cycles (grant, memory cycle, DONE); the requester may drop or change its request in the cycle after ready.
REQ-024 if_rdata/dm_rdata hold their last captured value until the next read completion for that port.
REQ-025 mem_valid seen in IDLE or DONE is ignored; no ready is generated.
REQ-026 Fetch and data ready never assert in the same cycle; at most one transaction is outstanding.

Reset
REQ-027 rst=1 at an edge: state=IDLE, starve_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
REQ-028 rst during *_WAIT aborts the transaction with no ready pulse; a late mem_valid is ignored per REQ-025.

Structure
REQ-029 Shared package wisc_pkg holds the arb_state_t enum, default ADDR_W/DATA_W, and opcode localparams (LW=4'b1000, SW=4'b1001, CALL=4'b1101, RET=4'b1110).
REQ-030 Single module with no sub-module; starve_cnt is a $clog2(STARVE_MAX+1)-bit counter inside.

Verification
REQ-031 Fetch only: if_req=1, if_addr=16'h0010, mem_valid 2 cycles after mem_en with mem_rdata=16'hA5A5 -> mem_en one cycle with mem_addr=16'h0010, mem_we=0; then if_ready one cycle with if_rdata=16'hA5A5.
REQ-032 Simultaneous: if_req=1 and dm_we=1, dm_addr=16'h0200, dm_wdata=16'h1234 -> data granted first (mem_we=1, mem_wdata=16'h1234); dm_ready, then fetch granted on the next IDLE cycle.
REQ-033 Starvation: if_req held, dm_re asserted continuously, STARVE_MAX=4 -> exactly 4 dm_ready pulses, then one if_ready pulse, then data resumes.
REQ-034 Reset mid-wait: rst pulsed in DM_WAIT, mem_valid one cycle later -> no dm_ready; all outputs at reset values; the next request grants normally.
REQ-035 dm_re=dm_we=1, dm_addr=16'h0040 -> mem_we=1; dm_ready pulses; dm_rdata unchanged from its prior value.

Source files
------------

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared arbiter state type, default bus widths and opcode constants
package wisc_pkg;
  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, DONE} arb_state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [3:0] LW   = 4'b1000;
  localparam logic [3:0] SW   = 4'b1001;
  localparam logic [3:0] CALL = 4'b1101;
  localparam logic [3:0] RET  = 4'b1110;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory port bundle; master = requesters+memory, slave = arbiter
interface mem_arbiter_if import wisc_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_re;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  modport master (
    output if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  if_req, if_addr, dm_re, dm_we, dm_addr, dm_wdata, mem_rdata, mem_valid,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter, data over fetch with starvation guard; ports clk, rst, bus (slave of mem_arbiter_if)
module mem_arbiter import wisc_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  arb_state_t        state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic              if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              dm_req, starved, grant_if;
  assign dm_req   = bus.dm_re | bus.dm_we;
  assign starved  = starve_q == CW'(STARVE_MAX);
  assign grant_if = bus.if_req & (~dm_req | starved);
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d    = IF_WAIT;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          starve_d   = '0;
        end else if (dm_req) begin
          state_d     = DM_WAIT;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          starve_d    = !bus.if_req ? '0 : starved ? starve_q : starve_q + 1'b1;
        end
      end
      IF_WAIT: begin
        state_d    = bus.mem_valid ? DONE : IF_WAIT;
        if_ready_d = bus.mem_valid;
        if_rdata_d = bus.mem_valid ? bus.mem_rdata : if_rdata_q;
      end
      DM_WAIT: begin
        state_d    = bus.mem_valid ? DONE : DM_WAIT;
        dm_ready_d = bus.mem_valid;
        dm_rdata_d = (bus.mem_valid && !mem_we_q) ? bus.mem_rdata : dm_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int SMAX = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int pend, starve, lat, force_lat;
  bit free, hold, force_valid;
  logic e_en, e_we, e_ifr, e_dmr;
  logic [15:0] e_addr, e_wd, e_ifd, e_dmd;
  logic [15:0] mem [logic [15:0]];
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  function automatic logic [15:0] rd(logic [15:0] a);
    return mem.exists(a) ? mem[a] : a ^ 16'h5A5A;
  endfunction
  task automatic predict();
    logic dmq;
    dmq = bus.dm_re | bus.dm_we;
    e_en = 0; e_ifr = 0; e_dmr = 0;
    if (rst) begin
      free = 1; hold = 0; pend = 0; starve = 0;
      e_we = 0; e_addr = 0; e_wd = 0; e_ifd = 0; e_dmd = 0;
    end else if (free) begin
      if (bus.if_req && (!dmq || starve == SMAX)) begin
        pend = 1; starve = 0; e_we = 0; e_addr = bus.if_addr;
      end else if (dmq) begin
        pend = 2;
        starve = bus.if_req ? (starve < SMAX ? starve + 1 : SMAX) : 0;
        e_we = bus.dm_we; e_addr = bus.dm_addr;
        if (bus.dm_we) e_wd = bus.dm_wdata;
      end
      if (pend != 0) begin
        free = 0; e_en = 1;
        lat = force_lat != 0 ? force_lat : int'($urandom_range(1, 3));
      end
    end else if (pend != 0 && bus.mem_valid) begin
      if (pend == 1) begin e_ifr = 1; e_ifd = bus.mem_rdata; end
      else begin e_dmr = 1; if (!e_we) e_dmd = bus.mem_rdata; end
      pend = 0; hold = 1;
    end else if (hold) begin
      hold = 0; free = 1;
    end
  endtask
  task automatic tick();
    if (force_valid) begin
      bus.mem_valid = 1; bus.mem_rdata = 16'($urandom);
    end else if (pend != 0) begin
      bus.mem_valid = (lat == 1);
      lat--;
      if (lat == 0) begin
        if (e_we) begin mem[e_addr] = e_wd; bus.mem_rdata = 16'($urandom); end
        else bus.mem_rdata = rd(e_addr);
      end
    end else begin
      bus.mem_valid = ($urandom % 8 == 0); bus.mem_rdata = 16'($urandom);
    end
    predict();
    @(posedge clk); #1;
    chk("mem_en", bus.mem_en, e_en);
    chk("mem_we", bus.mem_we, e_we);
    chk("mem_addr", bus.mem_addr, e_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("if_ready", bus.if_ready, e_ifr);
    chk("dm_ready", bus.dm_ready, e_dmr);
    chk("if_rdata", bus.if_rdata, e_ifd);
    chk("dm_rdata", bus.dm_rdata, e_dmd);
  endtask
  task automatic wait_ready(output int which, input int max);
    which = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.if_ready) begin which = 1; return; end
      if (bus.dm_ready) begin which = 2; return; end
    end
    chk("ready_timeout", which, 3);
  endtask
  initial begin
    int w, n, op;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_re = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0; bus.mem_valid = 0;
    pend = 0; starve = 0; lat = 0; force_lat = 0; force_valid = 0; free = 1; hold = 0;
    tick(); tick();
    rst = 0;
    mem[16'h0010] = 16'hA5A5; force_lat = 2;
    bus.if_req = 1; bus.if_addr = 16'h0010;
    wait_ready(w, 20);
    chk("t031_port", w, 1);
    chk("t031_rdata", bus.if_rdata, 16'hA5A5);
    bus.if_req = 0; force_lat = 0;
    tick(); tick();
    bus.if_req = 1; bus.if_addr = 16'h0100;
    bus.dm_we = 1; bus.dm_addr = 16'h0200; bus.dm_wdata = 16'h1234;
    wait_ready(w, 20);
    chk("t032_first", w, 2);
    bus.dm_we = 0;
    wait_ready(w, 20);
    chk("t032_second", w, 1);
    bus.if_req = 0;
    bus.dm_re = 1; bus.dm_addr = 16'h0200;
    wait_ready(w, 20);
    chk("rb_port", w, 2);
    chk("rb_data", bus.dm_rdata, 16'h1234);
    bus.dm_re = 0;
    bus.dm_re = 1; bus.dm_we = 1; bus.dm_addr = 16'h0040; bus.dm_wdata = 16'hBEEF;
    wait_ready(w, 20);
    chk("t035_port", w, 2);
    chk("t035_rdata", bus.dm_rdata, 16'h1234);
    bus.dm_re = 0; bus.dm_we = 0;
    bus.if_req = 1; bus.if_addr = 16'h0300; bus.dm_re = 1; bus.dm_addr = 16'h0400;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      wait_ready(w, 20);
      if (w != 2) break;
      n++;
      bus.dm_addr = bus.dm_addr + 16'd1;
    end
    chk("t033_dm_count", n, 4);
    chk("t033_then_if", w, 1);
    bus.if_req = 0;
    wait_ready(w, 20);
    chk("t033_resume", w, 2);
    bus.dm_re = 0;
    tick();
    bus.dm_re = 1; bus.dm_addr = 16'h0050; force_lat = 6;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_en) break;
    end
    chk("t034_grant", bus.mem_en, 1);
    tick();
    rst = 1;
    tick();
    rst = 0; force_lat = 0; force_valid = 1;
    tick();
    force_valid = 0;
    chk("t034_no_ready", bus.dm_ready, 0);
    chk("t034_regrant", bus.mem_en, 1);
    wait_ready(w, 20);
    chk("t034_port", w, 2);
    bus.dm_re = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 400 == 0);
      tick();
      if (bus.if_ready) bus.if_req = 0;
      if (bus.dm_ready) begin bus.dm_re = 0; bus.dm_we = 0; end
      if (!bus.if_req && $urandom % 3 == 0) begin
        bus.if_req = 1; bus.if_addr = 16'($urandom % 64);
      end
      if (!(bus.dm_re | bus.dm_we) && $urandom % 2 == 0) begin
        op = int'($urandom % 4);
        bus.dm_re = (op != 2); bus.dm_we = (op >= 2);
        bus.dm_addr = 16'($urandom % 64); bus.dm_wdata = 16'($urandom);
      end
    end
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
